// File: rtl/mem_responder.sv
// Bus-side memory responder: one request at a time, serviced from a byte RAM
// after WAIT wait states, with a parameter-driven reset vector at FFFC/FFFD.
module mem_responder #(
  parameter int          MEM_AW    = 10,
  parameter int          WAIT      = 1,
  parameter logic [15:0] RESET_VEC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT);
  localparam logic [16:0] RAM_BYTES = 17'(1) << MEM_AW;
  localparam logic [15:0] VEC_LO    = 16'hFFFC;
  localparam logic [15:0] VEC_HI    = 16'hFFFD;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        overrun_q, overrun_d;

  logic [7:0]  mem [2**MEM_AW];

  logic        accept;
  logic        enterResp;
  logic        commitWrite;
  logic [15:0] lookupAddr;
  logic        lookupRw;
  logic [7:0]  lookupData;

  function automatic logic isRam(input logic [15:0] a);
    return {1'b0, a} < RAM_BYTES;
  endfunction

  assign accept      = req && (state_q == ST_IDLE || state_q == ST_RESP);
  assign commitWrite = (state_q == ST_RESP) && !rw_q && isRam(addr_q);
  assign enterResp   = (accept && (WAIT_CNT == 4'd0)) ||
                       ((state_q == ST_WAIT) && (cnt_q <= 4'd1));

  // With WAIT=0 the response is loaded on the accepting edge, so the lookup
  // must use the live bus address rather than the latched one.
  assign lookupAddr = (state_q == ST_WAIT) ? addr_q : addr;
  assign lookupRw   = (state_q == ST_WAIT) ? rw_q   : rw;

  // A write committing on this same edge is forwarded to a read of its address.
  always_comb begin
    lookupData = 8'hFF;
    if (isRam(lookupAddr)) begin
      if (commitWrite && (addr_q == lookupAddr)) begin
        lookupData = wdata_q;
      end else begin
        lookupData = mem[lookupAddr[MEM_AW-1:0]];
      end
    end else if (lookupAddr == VEC_LO) begin
      lookupData = RESET_VEC[7:0];
    end else if (lookupAddr == VEC_HI) begin
      lookupData = RESET_VEC[15:8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (req) begin
          overrun_d = 1'b1;
        end
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enterResp && lookupRw) begin
      rdata_d = lookupData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      rw_q      <= 1'b1;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
    end
  end

  // RAM has no reset; an aborted write never reaches RESP so it is never committed.
  always_ff @(posedge clk) begin
    if (commitWrite) begin
      mem[addr_q[MEM_AW-1:0]] <= wdata_q;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = (state_q == ST_RESP);
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (WAIT = 0, 1, 3) driven by directed and
// random accesses, compared against a plain array model of the memory map.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        rw    [3];
  logic [15:0] addr  [3];
  logic [7:0]  wdata [3];
  logic [7:0]  rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic        overrun [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] memModel [3][1024];
  bit         memValid [3][1024];
  logic [7:0] expRdata [3];

  always #5 clk = ~clk;

  mem_responder #(.MEM_AW(10), .WAIT(0), .RESET_VEC(16'h0200)) u0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]),
    .overrun(overrun[0]));

  mem_responder #(.MEM_AW(10), .WAIT(1), .RESET_VEC(16'h0200)) u1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]),
    .overrun(overrun[1]));

  mem_responder #(.MEM_AW(10), .WAIT(3), .RESET_VEC(16'h0200)) u3 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .rw(rw[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]),
    .overrun(overrun[2]));

  function automatic int waitOf(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [7:0] modelRead(input int k, input logic [15:0] a);
    if (a < 16'h0400) return memModel[k][a[9:0]];
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'h02;
    return 8'hFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic [15:0] a, input logic [7:0] d);
    req[k]   = 1'b1;
    rw[k]    = r;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // One isolated access: checks latency, one-cycle ready and read data.
  task automatic applyStimulus(input int k, input logic r, input logic [15:0] a, input logic [7:0] d);
    int lat;
    bit seen;
    @(negedge clk);
    drive(k, r, a, d);
    @(posedge clk);
    @(negedge clk);
    req[k] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (ready[k]) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("readySeen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("latency", 32'(lat), 32'(waitOf(k) + 1));
      if (r) begin
        expRdata[k] = modelRead(k, a);
      end else if (a < 16'h0400) begin
        memModel[k][a[9:0]] = d;
        memValid[k][a[9:0]] = 1'b1;
      end
      checkOutput(r ? "readData" : "rdataHeldOnWrite", 32'(rdata[k]), 32'(expRdata[k]));
      @(negedge clk);
      checkOutput("readyPulse", 32'(ready[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [7:0]  got;
    logic [15:0] a;
    int          cnt;
    int          op;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req[k] = 1'b0; rw[k] = 1'b1; addr[k] = '0; wdata[k] = '0;
      expRdata[k] = 8'h00;
      for (int i = 0; i < 1024; i++) memValid[k][i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("rstRdata", 32'(rdata[k]), 32'h00);
      checkOutput("rstReady", 32'(ready[k]), 32'd0);
      checkOutput("rstBusy", 32'(busy[k]), 32'd0);
      checkOutput("rstOverrun", 32'(overrun[k]), 32'd0);
      rst[k] = 1'b1;
    end
    @(negedge clk);

    $display("[TB] write/read, vectors and unmapped on WAIT=1");
    applyStimulus(1, 1'b0, 16'h0123, 8'h3C);
    applyStimulus(1, 1'b1, 16'h0123, 8'h00);
    checkOutput("rd0123", 32'(rdata[1]), 32'h3C);
    applyStimulus(1, 1'b1, 16'hFFFC, 8'h00);
    checkOutput("vecLo", 32'(rdata[1]), 32'h00);
    applyStimulus(1, 1'b1, 16'hFFFD, 8'h00);
    checkOutput("vecHi", 32'(rdata[1]), 32'h02);
    applyStimulus(1, 1'b0, 16'hFFFC, 8'h55);
    applyStimulus(1, 1'b1, 16'hFFFC, 8'h00);
    checkOutput("vecLoAfterWrite", 32'(rdata[1]), 32'h00);
    applyStimulus(1, 1'b1, 16'h8000, 8'h00);
    checkOutput("unmapped", 32'(rdata[1]), 32'hFF);

    $display("[TB] back-to-back reads on WAIT=0");
    for (int j = 0; j < 4; j++) applyStimulus(0, 1'b0, 16'(j), 8'(j + 1));
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 8'h00);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("b2bReady", 32'(ready[0]), 32'd1);
      checkOutput("b2bData", 32'(rdata[0]), 32'(j + 1));
      if (j < 3) addr[0] = 16'(j + 1);
      else req[0] = 1'b0;
    end
    expRdata[0] = 8'h04;
    @(negedge clk);
    checkOutput("b2bEnd", 32'(ready[0]), 32'd0);

    $display("[TB] write-then-read hazard");
    @(negedge clk);
    drive(1, 1'b0, 16'h0040, 8'h9A);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    checkOutput("hazW1Ready", 32'(ready[1]), 32'd1);
    drive(1, 1'b1, 16'h0040, 8'h00);
    @(negedge clk);
    req[1] = 1'b0;
    checkOutput("hazR1Wait", 32'(ready[1]), 32'd0);
    @(negedge clk);
    checkOutput("hazR1Ready", 32'(ready[1]), 32'd1);
    checkOutput("hazR1Data", 32'(rdata[1]), 32'h9A);
    memModel[1][16'h040] = 8'h9A; memValid[1][16'h040] = 1'b1; expRdata[1] = 8'h9A;

    @(negedge clk);
    drive(0, 1'b0, 16'h0041, 8'h5B);
    @(negedge clk);
    checkOutput("hazW0Ready", 32'(ready[0]), 32'd1);
    drive(0, 1'b1, 16'h0041, 8'h00);
    @(negedge clk);
    req[0] = 1'b0;
    checkOutput("hazR0Ready", 32'(ready[0]), 32'd1);
    checkOutput("hazR0Data", 32'(rdata[0]), 32'h5B);
    memModel[0][16'h041] = 8'h5B; memValid[0][16'h041] = 1'b1; expRdata[0] = 8'h5B;
    @(negedge clk);
    checkOutput("hazR0End", 32'(ready[0]), 32'd0);

    $display("[TB] overrun on WAIT=3");
    v = 8'($urandom_range(0, 255));
    applyStimulus(2, 1'b0, 16'h0020, v);
    @(negedge clk);
    drive(2, 1'b1, 16'h0020, 8'h00);
    @(negedge clk);
    req[2] = 1'b0;
    checkOutput("ovrBefore", 32'(overrun[2]), 32'd0);
    @(negedge clk);
    drive(2, 1'b0, 16'h0020, ~v);
    @(negedge clk);
    req[2] = 1'b0;
    cnt = 0;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (ready[2]) begin
        cnt++;
        got = rdata[2];
      end
      @(negedge clk);
    end
    checkOutput("ovrFlag", 32'(overrun[2]), 32'd1);
    checkOutput("ovrReadyCount", 32'(cnt), 32'd1);
    checkOutput("ovrData", 32'(got), 32'(v));
    expRdata[2] = v;
    applyStimulus(2, 1'b1, 16'h0020, 8'h00);
    checkOutput("ovrDroppedWrite", 32'(rdata[2]), 32'(v));
    checkOutput("ovrSticky", 32'(overrun[2]), 32'd1);

    $display("[TB] reset during a write on WAIT=3");
    applyStimulus(2, 1'b0, 16'h0010, 8'h11);
    @(negedge clk);
    drive(2, 1'b0, 16'h0010, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy[2]), 32'd0);
    checkOutput("midRstReady", 32'(ready[2]), 32'd0);
    checkOutput("midRstRdata", 32'(rdata[2]), 32'h00);
    checkOutput("midRstOverrun", 32'(overrun[2]), 32'd0);
    expRdata[2] = 8'h00;
    repeat (2) @(negedge clk);
    rst[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready[2]) cnt++;
    end
    checkOutput("midRstNoReady", 32'(cnt), 32'd0);
    applyStimulus(2, 1'b1, 16'h0010, 8'h00);
    checkOutput("midRstRamKept", 32'(rdata[2]), 32'h11);

    $display("[TB] random accesses");
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 14; n++) begin
        op = int'($urandom_range(0, 3));
        if (op == 0) begin
          case ($urandom_range(0, 2))
            0: a = 16'hFFFC;
            1: a = 16'hFFFD;
            default: a = 16'h0400 + 16'($urandom_range(0, 16'hFBF0));
          endcase
          applyStimulus(k, $urandom_range(0, 1) == 1, a, 8'($urandom_range(0, 255)));
        end else begin
          a = 16'($urandom_range(0, 63));
          if (op == 1 || !memValid[k][a[9:0]])
            applyStimulus(k, 1'b0, a, 8'($urandom_range(0, 255)));
          else
            applyStimulus(k, 1'b1, a, 8'h00);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus-side responder for the CPU core: the agent at the other end of the core's 16-bit address / 8-bit data bus. It accepts one read or write request at a time, services it from an internal byte RAM after a programmable number of wait states, and answers reset-vector fetches from a parameter. It sits beside the core and the clock generator in the top level and replaces the constant data-bus tie-off.

## Interface
- `MEM_AW`, default 10: RAM address width; RAM holds 2^MEM_AW bytes mapped at 16'h0000.
- `WAIT`, default 1: wait states per access; legal range 0..15.
- `RESET_VEC`, default 16'h0200: value returned for the reset-vector fetch at 16'hFFFC/16'hFFFD.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `req` input 1: request strobe; `addr`, `rw` and `wdata` are sampled in any cycle where `req`=1 and the request is accepted.
- `rw` input 1: 1 = read, 0 = write.
- `addr` input 16: byte address.
- `wdata` input 8: write data.
- `rdata` output 8: read data; valid when `ready`=1, held afterwards.
- `ready` output 1: one-cycle completion pulse, for reads and for writes.
- `busy` output 1: a request is in flight (WAIT or RESP state).
- `overrun` output 1: sticky flag, set when a request is dropped.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Accept: `req`=1 while in IDLE or RESP latches `addr`, `rw`, `wdata` and loads the wait counter with `WAIT`.
  - If `WAIT`>0, the next state is WAIT.
  - If `WAIT`=0, the next state is RESP.
- WAIT state: decrement the counter each cycle; move to RESP on the cycle the counter reaches 1.
- RESP state: `ready`=1 for exactly this cycle. Then:
  - with no new `req`, go to IDLE;
  - with a new `req`, accept it, giving back-to-back service.
- `req` while in WAIT: the request is dropped, `overrun` is set, and the in-flight access is unaffected.
- Address decode uses the latched address:
  - addr < 2^MEM_AW: RAM at index addr[MEM_AW-1:0].
  - 16'hFFFC: reads return RESET_VEC[7:0]; writes are ignored.
  - 16'hFFFD: reads return RESET_VEC[15:8]; writes are ignored.
  - Any other address is unmapped: reads return 8'hFF; writes are dropped; no error is flagged.
- Reads: `rdata` is loaded entering RESP and holds its value until the next read completes. Writes do not change `rdata`.
- Writes: the RAM is updated at the RESP cycle edge. A read of the same address that is accepted in that RESP cycle returns the new data.
- `busy` = (state != IDLE).

## Timing
- Reset values while `rst`=0: state IDLE, `rdata`=8'h00, `ready`=0, `busy`=0, `overrun`=0, counter 0.
- RAM contents are not reset and are undefined until written.
- Latency: for a request accepted at edge N, `ready` is high in the cycle after edge N+WAIT. That is WAIT+1 cycles from acceptance to response.
- Throughput: one access per WAIT+1 cycles with back-to-back requests.
- Reset asserted mid-access:
  - the access is aborted immediately (asynchronously);
  - a pending write is discarded and the RAM is not modified;
  - `ready` is not issued.
- Release of `rst` takes effect synchronously at the next edge.
- `overrun` is cleared only by reset.

## Test plan
- Reset: drive `rst`=0 mid-stream -> `rdata`=8'h00, `ready`=0, `busy`=0, `overrun`=0. With `rst`=0 during the WAIT of a write to 16'h0010=8'hA5, a later read of 16'h0010 must not return 8'hA5 (preload 8'h11 first; the read must return 8'h11).
- Write/read, WAIT=1:
  - write 8'h3C to 16'h0123 -> `ready` pulses 2 cycles after acceptance;
  - read 16'h0123 -> `rdata`=8'h3C with `ready` 2 cycles after acceptance.
- Vector and unmapped:
  - read 16'hFFFC / 16'hFFFD -> 8'h00 / 8'h02;
  - write 8'h55 to 16'hFFFC then read -> still 8'h00;
  - read 16'h8000 -> 8'hFF.
- Back-to-back, WAIT=0: hold `req` for 4 cycles reading 16'h0000..16'h0003, preloaded 8'h01..8'h04 -> `ready` high 4 consecutive cycles with `rdata` 01, 02, 03, 04.
- Overrun, WAIT=3: issue a read, then pulse `req` in the second WAIT cycle -> `overrun`=1, exactly one `ready`, correct first-read data.
- Write-then-read hazard: write 8'h9A to 16'h0040; in its RESP cycle issue a read of 16'h0040 -> the read returns 8'h9A.
